// File: rtl/m72_pkg.sv
// Shared types for the SDRAM channel-3 arbiter: owner encoding (drives grant),
// FSM states and the default watchdog limit.
package m72_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ROM  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DBG  = 2'd3
  } sdr_owner_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int unsigned SDR_ARB_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/sdr_ch3_arbiter.sv
// SDRAM channel-3 arbiter: ROM download writes, CPU reads/writes and debug
// read-back share one channel. Registered request path, one transaction in
// flight, CPU/DBG round-robin, per-requester rdy pulse and read-data register.
// Optional WAIT watchdog enabled by defining SDR_ARB_TIMEOUT_EN.
module sdr_ch3_arbiter
  import m72_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = SDR_ARB_TIMEOUT_DEFAULT,
  parameter int          AW             = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          download_active,
  input  logic [AW:1]   rom_addr,
  input  logic [15:0]   rom_din,
  input  logic [1:0]    rom_be,
  input  logic          rom_req,
  output logic          rom_rdy,
  input  logic [AW:1]   cpu_addr,
  input  logic [15:0]   cpu_din,
  input  logic [1:0]    cpu_wr_sel,
  input  logic          cpu_req,
  output logic          cpu_rdy,
  output logic [15:0]   cpu_dout,
  input  logic [AW:1]   dbg_addr,
  input  logic          dbg_req,
  output logic          dbg_rdy,
  output logic [15:0]   dbg_dout,
  output logic [AW:1]   ch3_addr,
  output logic [15:0]   ch3_din,
  output logic [1:0]    ch3_be,
  output logic          ch3_rnw,
  output logic          ch3_req,
  input  logic          ch3_ready,
  input  logic [15:0]   ch3_dout,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  arb_state_t r_state, w_next;
  sdr_owner_t r_grant, w_win;
  logic [AW:1] r_addr;
  logic [15:0] r_din, r_cpu_dout, r_dbg_dout;
  logic [1:0]  r_be;
  logic        r_rnw, r_rom_rdy, r_cpu_rdy, r_dbg_rdy;
  logic        r_last_dbg;   // 1: DBG was served last, so CPU wins a tie
  logic        w_expire, w_done_evt;

`ifdef SDR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  // WAIT-cycle counter, cleared whenever the FSM is elsewhere
  always_ff @(posedge clk) begin
    if (reset || r_state != ST_WAIT) r_wait_cnt <= '0;
    else                             r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  assign w_expire = (r_state == ST_WAIT) && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // sticky watchdog flag; a real ch3_ready on the expiry cycle takes precedence
  always_ff @(posedge clk) begin
    if (reset)                      r_timeout_err <= 1'b0;
    else if (w_expire && !ch3_ready) r_timeout_err <= 1'b1;
  end

  assign timeout_err = r_timeout_err;
`else
  // watchdog absent: WAIT waits indefinitely and the flag is tied low
  assign w_expire    = 1'b0;
  assign timeout_err = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

  assign w_done_evt = (r_state == ST_WAIT) && (ch3_ready || w_expire);

  // winner selection: download locks out CPU/DBG; otherwise 2-way round-robin
  always_comb begin
    w_win = OWN_NONE;
    if (download_active) begin
      if (rom_req) w_win = OWN_ROM;
    end else if (cpu_req && (!dbg_req || r_last_dbg)) begin
      w_win = OWN_CPU;
    end else if (dbg_req) begin
      w_win = OWN_DBG;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_win != OWN_NONE) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_done_evt) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: the SDRAM request is a single-cycle pulse in ISSUE
  always_comb begin
    ch3_req = (r_state == ST_ISSUE);
  end

  // datapath: latch winner, capture read data, pulse owner's rdy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant    <= OWN_NONE;
      r_addr     <= '0;
      r_din      <= '0;
      r_be       <= '0;
      r_rnw      <= 1'b1;
      r_rom_rdy  <= 1'b0;
      r_cpu_rdy  <= 1'b0;
      r_dbg_rdy  <= 1'b0;
      r_cpu_dout <= '0;
      r_dbg_dout <= '0;
      r_last_dbg <= 1'b1;
    end else begin
      r_rom_rdy <= 1'b0;
      r_cpu_rdy <= 1'b0;
      r_dbg_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_grant <= w_win;
          case (w_win)
            OWN_ROM: begin
              r_addr <= rom_addr; r_din <= rom_din; r_be <= rom_be; r_rnw <= 1'b0;
            end
            OWN_CPU: begin
              r_addr     <= cpu_addr;
              r_din      <= cpu_din;
              r_be       <= (|cpu_wr_sel) ? cpu_wr_sel : 2'b11;
              r_rnw      <= ~|cpu_wr_sel;
              r_last_dbg <= 1'b0;
            end
            OWN_DBG: begin
              r_addr <= dbg_addr; r_din <= '0; r_be <= 2'b11; r_rnw <= 1'b1;
              r_last_dbg <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_WAIT: if (w_done_evt) begin
          case (r_grant)
            OWN_ROM: r_rom_rdy <= 1'b1;
            OWN_CPU: begin
              r_cpu_rdy <= 1'b1;
              if (r_rnw) r_cpu_dout <= ch3_ready ? ch3_dout : 16'hFFFF;
            end
            OWN_DBG: begin
              r_dbg_rdy <= 1'b1;
              if (r_rnw) r_dbg_dout <= ch3_ready ? ch3_dout : 16'hFFFF;
            end
            default: ;
          endcase
        end
        ST_DONE: r_grant <= OWN_NONE;
        default: ;
      endcase
    end
  end

  assign grant    = r_grant;
  assign ch3_addr = r_addr;
  assign ch3_din  = r_din;
  assign ch3_be   = r_be;
  assign ch3_rnw  = r_rnw;
  assign rom_rdy  = r_rom_rdy;
  assign cpu_rdy  = r_cpu_rdy;
  assign dbg_rdy  = r_dbg_rdy;
  assign cpu_dout = r_cpu_dout;
  assign dbg_dout = r_dbg_dout;

endmodule
